// File: rtl/riscv_wb_scoreboard_if.sv
// Purpose: bundles the execute/LSU-to-regfile write-port signals of riscv_wb_scoreboard.
// Latency: n/a (wiring only).
// Backpressure: ld_ready_o gates load returns; ALU results and load issues are never stalled.
//
// Modports: master = upstream execute/LSU/decode plus regfile side; slave = the scoreboard.
// Optional: RISCV_WB_BYPASS_EN adds byp_rs1_hit_o, byp_rs2_hit_o and byp_data_o.
interface riscv_wb_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            alu_valid_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            ld_issue_i;
    logic [4:0]      ld_issue_rd_i;
    logic            ld_valid_i;
    logic            ld_ready_o;
    logic [4:0]      ld_rd_i;
    logic [XLEN-1:0] ld_data_i;
    logic [4:0]      dec_rs1_i;
    logic [4:0]      dec_rs2_i;
    logic [4:0]      dec_rd_i;
    logic            hazard_o;
    logic            wr_en_o;
    logic [4:0]      wr_addr_o;
    logic [XLEN-1:0] wr_data_o;
    logic [5:0]      ld_pending_o;
`ifdef RISCV_WB_BYPASS_EN
    logic            byp_rs1_hit_o;
    logic            byp_rs2_hit_o;
    logic [XLEN-1:0] byp_data_o;
`endif

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_issue_i, ld_issue_rd_i,
        output ld_valid_i, ld_rd_i, ld_data_i,
        output dec_rs1_i, dec_rs2_i, dec_rd_i,
        input  ld_ready_o, hazard_o, wr_en_o, wr_addr_o, wr_data_o, ld_pending_o
`ifdef RISCV_WB_BYPASS_EN
        , input byp_rs1_hit_o, byp_rs2_hit_o, byp_data_o
`endif
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_issue_i, ld_issue_rd_i,
        input  ld_valid_i, ld_rd_i, ld_data_i,
        input  dec_rs1_i, dec_rs2_i, dec_rd_i,
        output ld_ready_o, hazard_o, wr_en_o, wr_addr_o, wr_data_o, ld_pending_o
`ifdef RISCV_WB_BYPASS_EN
        , output byp_rs1_hit_o, byp_rs2_hit_o, byp_data_o
`endif
    );
endinterface

// File: rtl/riscv_wb_scoreboard.sv
// Purpose: merges ALU results and buffered load returns onto the single regfile write port; tracks busy regs.
// Latency: ALU 1 cycle to wr_*_o; load return min 2 cycles (always via the FIFO); hazard_o combinational.
// Backpressure: ld_ready_o = !full from the registered count; continuous ALU traffic may starve loads.
//
// Ports: clk, reset_n (async active-low) and bus (riscv_wb_scoreboard_if.slave) carrying the ALU
// result, load issue, load return (valid/ready), decode sources, regfile write port and ld_pending_o.
// Optional: RISCV_WB_BYPASS_EN enables the decode bypass outputs byp_rs1_hit_o/byp_rs2_hit_o/byp_data_o.
// The interface XLEN must match this module's XLEN.

// Generic FIFO used for load-return buffering. DEPTH must be a power of two so pointers wrap for free.
// Push must only be asserted when !full and pop only when !empty; the storage itself is not reset,
// only the pointers/count, so reset drops all buffered entries at once.
module riscv_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

module riscv_wb_scoreboard #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int XLEN          = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    riscv_wb_scoreboard_if.slave bus
);
    localparam int EW = 5 + XLEN;

    logic            fifo_full;
    logic            fifo_empty;
    logic            ld_push;
    logic            ld_pop;
    logic [EW-1:0]   head_dat;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    logic            sel_vld;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [5:0]      busy_cnt;

    logic            wr_en_q;
    logic [4:0]      wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic [5:0]      pending_q;

    // Ready depends only on the registered count, so a pop this cycle never frees a slot for a
    // same-cycle push; this keeps ld_ready_o free of any path from alu_valid_i.
    assign bus.ld_ready_o = !fifo_full;
    assign ld_push        = bus.ld_valid_i && !fifo_full;

    // ALU always wins the write port; the FIFO head drains only in ALU-idle cycles.
    assign ld_pop = !bus.alu_valid_i && !fifo_empty;

    riscv_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (ld_push),
        .push_dat ({bus.ld_rd_i, bus.ld_data_i}),
        .pop      (ld_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_rd   = head_dat[EW-1 -: 5];
    assign head_data = head_dat[XLEN-1:0];

    assign sel_vld  = bus.alu_valid_i || ld_pop;
    assign sel_rd   = bus.alu_valid_i ? bus.alu_rd_i   : head_rd;
    assign sel_data = bus.alu_valid_i ? bus.alu_data_i : head_data;

    // A popped load clears its busy bit on the same edge it reaches the write port; a new issue to
    // the same register in that cycle must survive, so the set is applied last.
    always_comb begin
        busy_nxt = busy;
        if (ld_pop && head_rd != 5'd0) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (bus.ld_issue_i && bus.ld_issue_rd_i != 5'd0) begin
            busy_nxt[bus.ld_issue_rd_i] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            busy_cnt = busy_cnt + 6'(busy[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= '0;
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            busy      <= busy_nxt;
            pending_q <= busy_cnt;
            // x0 targets still consume their source but never enable the write; address/data
            // only move on a real write so they hold across idle and x0 cycles.
            wr_en_q   <= sel_vld && (sel_rd != 5'd0);
            if (sel_vld && sel_rd != 5'd0) begin
                wr_addr_q <= sel_rd;
                wr_data_q <= sel_data;
            end
        end
    end

    assign bus.wr_en_o      = wr_en_q;
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign bus.ld_pending_o = pending_q;

    // The rd term stops decode from issuing an ALU op that would race an in-flight load (WAW).
    assign bus.hazard_o = (busy[bus.dec_rs1_i] && bus.dec_rs1_i != 5'd0) ||
                          (busy[bus.dec_rs2_i] && bus.dec_rs2_i != 5'd0) ||
                          (busy[bus.dec_rd_i]  && bus.dec_rd_i  != 5'd0);

`ifdef RISCV_WB_BYPASS_EN
    assign bus.byp_rs1_hit_o = wr_en_q && (wr_addr_q == bus.dec_rs1_i) && (bus.dec_rs1_i != 5'd0);
    assign bus.byp_rs2_hit_o = wr_en_q && (wr_addr_q == bus.dec_rs2_i) && (bus.dec_rs2_i != 5'd0);
    assign bus.byp_data_o    = wr_data_q;
`endif
endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Purpose: self-checking bench for riscv_wb_scoreboard; queue-based reference model plus write monitor.
// Latency: expected writes are stamped with the cycle they must appear on wr_*_o.
// Backpressure: the model accepts a load return only while its own queue holds fewer than DEPTH entries.
module tb_riscv_wb_scoreboard;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk;
    logic reset_n;

    riscv_wb_scoreboard_if #(.XLEN(XLEN)) bus ();

    riscv_wb_scoreboard #(
        .LD_FIFO_DEPTH (DEPTH),
        .XLEN          (XLEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference state
    ld_t         mq[$];      // load returns accepted but not yet written
    wr_t         xq[$];      // expected register-file writes
    logic [31:0] m_busy;
    int          prev_cnt;
    int          cyc;
    logic        last_rdy;

    int n_cmp;
    int n_err;

    // Stimulus for the next cycle
    logic        s_alu_v, s_iss, s_ldv;
    logic [4:0]  s_alu_rd, s_iss_rd, s_ld_rd, s_rs1, s_rs2, s_rd;
    logic [31:0] s_alu_d, s_ld_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_stim();
        s_alu_v = 0; s_alu_rd = 0; s_alu_d = 0;
        s_iss = 0;   s_iss_rd = 0;
        s_ldv = 0;   s_ld_rd = 0;  s_ld_d = 0;
        s_rs1 = 0;   s_rs2 = 0;    s_rd = 0;
    endtask

    task automatic apply_stim();
        bus.alu_valid_i   = s_alu_v;
        bus.alu_rd_i      = s_alu_rd;
        bus.alu_data_i    = s_alu_d;
        bus.ld_issue_i    = s_iss;
        bus.ld_issue_rd_i = s_iss_rd;
        bus.ld_valid_i    = s_ldv;
        bus.ld_rd_i       = s_ld_rd;
        bus.ld_data_i     = s_ld_d;
        bus.dec_rs1_i     = s_rs1;
        bus.dec_rs2_i     = s_rs2;
        bus.dec_rd_i      = s_rd;
    endtask

    // One clock cycle: drive after the edge, check and advance the model at the falling edge.
    task automatic step();
        ld_t  e;
        logic exp_hz;
        @(posedge clk);
        #1;
        apply_stim();
        @(negedge clk);
        last_rdy = (mq.size() < DEPTH);
        exp_hz = (m_busy[s_rs1] && s_rs1 != 0) || (m_busy[s_rs2] && s_rs2 != 0) ||
                 (m_busy[s_rd] && s_rd != 0);
        chk("ld_ready", bus.ld_ready_o, last_rdy);
        chk("hazard", bus.hazard_o, exp_hz);
        chk("ld_pending", bus.ld_pending_o, prev_cnt);
        prev_cnt = $countones(m_busy);
        if (s_alu_v) begin
            if (s_alu_rd != 0) xq.push_back('{rd: s_alu_rd, data: s_alu_d, cyc: cyc + 1});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0) begin
                xq.push_back('{rd: e.rd, data: e.data, cyc: cyc + 1});
                m_busy[e.rd] = 1'b0;
            end
        end
        if (s_ldv && last_rdy) mq.push_back('{rd: s_ld_rd, data: s_ld_d});
        if (s_iss && s_iss_rd != 0) m_busy[s_iss_rd] = 1'b1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input logic [4:0] probe_rs1);
        @(posedge clk);
        #2;
        clr_stim();
        s_rs1 = probe_rs1;
        apply_stim();
        reset_n = 1'b0;
        #1;
        chk("rst_wr_en", bus.wr_en_o, 1'b0);
        chk("rst_ld_ready", bus.ld_ready_o, 1'b1);
        chk("rst_ld_pending", bus.ld_pending_o, 6'd0);
        chk("rst_hazard", bus.hazard_o, 1'b0);
        mq.delete();
        xq.delete();
        m_busy   = '0;
        prev_cnt = 0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    // Monitor: every enabled write must match the oldest expected write, on the expected cycle.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                while (xq.size() > 0 && xq[0].cyc < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_write: got none expected rd=%0d data=%0h at cycle %0d",
                             xq[0].rd, xq[0].data, xq[0].cyc);
                    void'(xq.pop_front());
                end
                if (bus.wr_en_o) begin
                    if (xq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                                 bus.wr_addr_o, bus.wr_data_o, cyc);
                    end else begin
                        w = xq.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                        chk("wr_addr", bus.wr_addr_o, w.rd);
                        chk("wr_data", bus.wr_data_o, w.data);
                    end
                end
            end
        end
    end

    initial begin
        int idx;
        logic [4:0] rets [3];
        n_cmp = 0;
        n_err = 0;
        m_busy = '0;
        prev_cnt = 0;
        last_rdy = 1'b1;
        clr_stim();
        apply_stim();
        reset_n = 1'b0;
        #12;
        chk("init_wr_en", bus.wr_en_o, 1'b0);
        chk("init_wr_addr", bus.wr_addr_o, 5'd0);
        chk("init_wr_data", bus.wr_data_o, 32'd0);
        chk("init_ld_ready", bus.ld_ready_o, 1'b1);
        chk("init_ld_pending", bus.ld_pending_o, 6'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // ALU single write
        clr_stim(); s_alu_v = 1; s_alu_rd = 3; s_alu_d = 32'hDEADBEEF; step();
        clr_stim(); step();

        // Load lifecycle for x7
        clr_stim(); s_iss = 1; s_iss_rd = 7; step();
        clr_stim(); s_rs1 = 7; step(); step();
        s_ldv = 1; s_ld_rd = 7; s_ld_d = 32'h12345678; step();
        clr_stim(); s_rs1 = 7; repeat (4) step();

        // Arbitration and backpressure: ALU every cycle while three returns are offered
        rets = '{5'd10, 5'd11, 5'd12};
        for (int i = 0; i < 3; i++) begin
            clr_stim(); s_iss = 1; s_iss_rd = rets[i]; step();
        end
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            clr_stim();
            s_rs1 = rets[c % 3];
            if (c < 7) begin
                s_alu_v = 1; s_alu_rd = 5'(1 + c); s_alu_d = $urandom;
            end
            if (idx < 3) begin
                s_ldv = 1; s_ld_rd = rets[idx]; s_ld_d = 32'hA000_0000 + idx;
            end
            step();
            if (s_ldv && last_rdy) idx++;
        end

        // x0 writes and issues
        clr_stim(); s_alu_v = 1; s_alu_rd = 0; s_alu_d = 32'h1111; step();
        clr_stim(); s_ldv = 1; s_ld_rd = 0; s_ld_d = 32'h2222; step();
        clr_stim(); s_iss = 1; s_iss_rd = 0; step();
        clr_stim(); repeat (4) step();

        // Simultaneous clear and set on x9
        clr_stim(); s_iss = 1; s_iss_rd = 9; step();
        clr_stim(); s_ldv = 1; s_ld_rd = 9; s_ld_d = 32'h9999_0009; step();
        clr_stim(); s_iss = 1; s_iss_rd = 9; s_rs2 = 9; step();
        clr_stim(); s_rs2 = 9; repeat (3) step();

        // Reset mid-stream: two returns buffered behind ALU traffic, x5 busy
        clr_stim(); s_iss = 1; s_iss_rd = 5; s_alu_v = 1; s_alu_rd = 2; s_alu_d = 32'h5;
        s_ldv = 1; s_ld_rd = 20; s_ld_d = 32'h20; step();
        s_iss = 0; s_ld_rd = 21; s_ld_d = 32'h21; step();
        do_reset(5'd5);
        clr_stim(); s_rs1 = 5; step(); step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clr_stim();
            s_alu_v  = ($urandom_range(0, 9) < 4);
            s_alu_rd = 5'($urandom_range(0, 31));
            s_alu_d  = $urandom;
            s_iss    = ($urandom_range(0, 9) < 3);
            s_iss_rd = 5'($urandom_range(0, 31));
            s_ldv    = ($urandom_range(0, 9) < 4);
            s_ld_rd  = 5'($urandom_range(0, 31));
            s_ld_d   = $urandom;
            s_rs1    = 5'($urandom_range(0, 31));
            s_rs2    = 5'($urandom_range(0, 31));
            s_rd     = 5'($urandom_range(0, 31));
            step();
        end

        clr_stim();
        repeat (10) step();
        chk("drain_queue", 64'(xq.size()), 64'd0);
        chk("drain_fifo", 64'(mq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
